logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit; next-generation successor to the single-function 32-bit AND submodule of the ALU.
- Selects one of eight bitwise operations per transaction.
- Accepts operands over a valid/ready handshake and registers each result into an output buffer.
- Adds zero and all-ones flags and a completed-operation counter for the ALU top level and the test harness.

---
 rtl/logic_unit_pipe_pkg.sv | 17 +
 rtl/logic_result_fifo.sv | 60 ++++++
 rtl/logic_unit_pipe.sv | 93 +++++++++
 tb/tb_logic_unit_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined logic unit: operation encodings and select width.
package logic_unit_pipe_pkg;

  localparam int LOP_W = 3;

  typedef enum logic [LOP_W-1:0] {
    LOP_AND   = 3'd0,
    LOP_OR    = 3'd1,
    LOP_XOR   = 3'd2,
    LOP_NOR   = 3'd3,
    LOP_ANDN  = 3'd4,
    LOP_ORN   = 3'd5,
    LOP_XNOR  = 3'd6,
    LOP_PASSX = 3'd7
  } lop_e;

endpackage

// File: rtl/logic_result_fifo.sv
// Result buffer for the logic unit: DEPTH entries of result plus flags, push/pop with
// full/empty status and a look-ahead full used to register the upstream ready.
module logic_result_fifo #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_full_nxt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nxt;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
  end

  assign o_full_nxt = (w_count_nxt == CW'(DEPTH));

  // Storage holds data only; validity comes entirely from the control state below.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight selectable operations, buffered results with
// zero/all-ones flags and a count of results consumed downstream.
module logic_unit_pipe
  import logic_unit_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOP_W-1:0] in_op,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic             out_ones,
  output logic [CNT_W-1:0] op_count
);

  localparam int FW = WIDTH + 2;

  logic [WIDTH-1:0] w_z;
  logic [FW-1:0]    w_wr_data;
  logic [FW-1:0]    w_rd_data;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_full_nxt;
  logic             r_in_ready;
  logic [CNT_W-1:0] r_op_count;

  always_comb begin
    w_z = in_x;
    case (in_op)
      LOP_AND:   w_z = in_x & in_y;
      LOP_OR:    w_z = in_x | in_y;
      LOP_XOR:   w_z = in_x ^ in_y;
      LOP_NOR:   w_z = ~(in_x | in_y);
      LOP_ANDN:  w_z = in_x & ~in_y;
      LOP_ORN:   w_z = in_x | ~in_y;
      LOP_XNOR:  w_z = ~(in_x ^ in_y);
      LOP_PASSX: w_z = in_x;
      default:   w_z = in_x;
    endcase
  end

  assign w_wr_data = {&w_z, ~|w_z, w_z};
  assign w_push    = in_valid & r_in_ready;
  assign w_pop     = ~w_empty & out_ready;

  logic_result_fifo #(
    .DATA_W (FW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (w_wr_data),
    .o_data     (w_rd_data),
    .o_empty    (w_empty),
    .o_full     (w_full),
    .o_full_nxt (w_full_nxt)
  );

  // Ready is taken from the post-edge fill level, so a pop while full frees the slot a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
      r_op_count <= '0;
    end else begin
      r_in_ready <= ~w_full_nxt;
      if (w_pop) r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = ~w_empty;
  assign out_z     = w_empty ? '0 : w_rd_data[WIDTH-1:0];
  assign out_zero  = ~w_empty & w_rd_data[WIDTH];
  assign out_ones  = ~w_empty & w_rd_data[WIDTH+1];
  assign op_count  = r_op_count;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe with hand-computed expected results.
module tb_logic_unit_pipe;
  import logic_unit_pipe_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [LOP_W-1:0] in_op;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;
  logic             out_zero;
  logic             out_ones;
  logic [CNT_W-1:0] op_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_cnt;

  logic_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_zero  (out_zero),
    .out_ones  (out_ones),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_ops [8];

  initial begin
    exp_ops[0] = 32'hF000_000F;
    exp_ops[1] = 32'hFFF0_0FFF;
    exp_ops[2] = 32'h0FF0_0FF0;
    exp_ops[3] = 32'h000F_F000;
    exp_ops[4] = 32'h00F0_00F0;
    exp_ops[5] = 32'hF0FF_F0FF;
    exp_ops[6] = 32'hF00F_F00F;
    exp_ops[7] = 32'hF0F0_00FF;

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_x = '0; in_y = '0; out_ready = 1'b0;
    exp_cnt = '0;

    // Reset then idle
    repeat (3) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_z", 64'(out_z), 64'd0);
    chk("rst_flags", 64'({out_zero, out_ones}), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // All eight ops back-to-back
    in_x = 32'hF0F0_00FF; in_y = 32'hFF00_0F0F; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_op = 3'(i);
      step();
      chk($sformatf("op%0d_z", i), 64'(out_z), 64'(exp_ops[i]));
      chk($sformatf("op%0d_valid", i), 64'(out_valid), 64'd1);
      if (i > 0) exp_cnt = exp_cnt + 1'b1;
    end
    in_valid = 1'b0;
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("ops_drained", 64'(out_valid), 64'd0);
    chk("ops_count", 64'(op_count), 64'd8);

    // Flags
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = LOP_AND; in_x = 32'hAAAA_AAAA; in_y = 32'h5555_5555;
    step();
    in_valid = 1'b0;
    chk("and_z", 64'(out_z), 64'd0);
    chk("and_zero", 64'(out_zero), 64'd1);
    chk("and_ones", 64'(out_ones), 64'd0);
    out_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 1'b1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = LOP_XNOR; in_x = 32'h1234_5678; in_y = 32'h1234_5678;
    step();
    in_valid = 1'b0;
    chk("xnor_z", 64'(out_z), 64'hFFFF_FFFF);
    chk("xnor_ones", 64'(out_ones), 64'd1);
    chk("xnor_zero", 64'(out_zero), 64'd0);
    out_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("empty_flags", 64'({out_valid, out_zero, out_ones}), 64'd0);
    chk("flags_count", 64'(op_count), 64'(exp_cnt));

    // Backpressure with three offered beats
    out_ready = 1'b0; in_valid = 1'b1; in_op = LOP_PASSX; in_y = '0;
    in_x = 32'd1; step();
    in_x = 32'd2; step();
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    in_x = 32'd3; step();
    chk("bp_still_blocked", 64'(in_ready), 64'd0);
    chk("bp_head_hold", 64'(out_z), 64'd1);
    out_ready = 1'b1; step();
    exp_cnt = exp_cnt + 1'b1;
    out_ready = 1'b0;
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    chk("bp_head2", 64'(out_z), 64'd2);
    step();
    in_valid = 1'b0;
    chk("bp_refill_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1; step();
    exp_cnt = exp_cnt + 1'b1;
    chk("bp_head3", 64'(out_z), 64'd3);
    step();
    exp_cnt = exp_cnt + 1'b1;
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_count", 64'(op_count), 64'(exp_cnt));

    // Simultaneous push/pop at one entry
    out_ready = 1'b0; in_valid = 1'b1; in_x = 32'd100; step();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_x = 32'(101 + i);
      step();
      exp_cnt = exp_cnt + 1'b1;
      chk($sformatf("pp%0d_z", i), 64'(out_z), 64'(100 + i + 1));
      chk($sformatf("pp%0d_rdy", i), 64'({out_valid, in_ready}), 64'd3);
    end
    chk("pp_count", 64'(op_count), 64'(exp_cnt));
    in_valid = 1'b0; step();
    exp_cnt = exp_cnt + 1'b1;
    chk("pp_drained", 64'(out_valid), 64'd0);

    // Counter wrap after a fresh reset
    rst_n = 1'b0; #1;
    chk("wrap_rst_count", 64'(op_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_x = 32'(i);
      step();
    end
    in_valid = 1'b0; step();
    chk("wrap_count", 64'(op_count), 64'd1);

    // Mid-operation reset with two buffered entries
    out_ready = 1'b0; in_valid = 1'b1;
    in_x = 32'hA; step();
    in_x = 32'hB; step();
    in_valid = 1'b0;
    chk("mid_full", 64'({out_valid, in_ready}), 64'd2);
    #2 rst_n = 1'b0; #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_count", 64'(op_count), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_z", 64'(out_z), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
